vga_scanout_engine: RTL and testbench



---
 rtl/vga_scanout_engine_if.sv | 20 ++
 rtl/vga_scanout_engine.sv | 156 +++++++++++++++
 tb/tb_vga_scanout_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vga_scanout_engine_if.sv
// Framebuffer read port and VGA pin bundle for vga_scanout_engine.
// The engine uses the master side; the memory/display side uses the slave side.
interface vga_scanout_engine_if;
    logic [15:0] vgaAddress;
    logic [15:0] vgaData;
    logic        Hsync;
    logic        Vsync;
    logic [7:0]  colorOut;
    logic        vblank;

    modport master (
        output vgaAddress, Hsync, Vsync, colorOut, vblank,
        input  vgaData
    );

    modport slave (
        input  vgaAddress, Hsync, Vsync, colorOut, vblank,
        output vgaData
    );
endinterface

// File: rtl/vga_scanout_engine.sv
// Parametrised VGA scanout: sync timing, framebuffer word addressing and pixel unpacking,
// with colour and sync delayed together to match the framebuffer read latency.
module vga_scanout_engine #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          PIX_DIV     = 2,
    parameter int          MEM_LATENCY = 1,
    parameter int          SCALE_LOG2  = 0,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic        SYNC_POL    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_scanout_engine_if.master vga
);
    localparam logic [15:0] DIV_LAST   = 16'(PIX_DIV - 1);
    localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] ROW_WORDS  = 16'((H_ACTIVE >> SCALE_LOG2) / 2);
    localparam logic [15:0] SCALE_MASK = 16'((1 << SCALE_LOG2) - 1);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic vb;
        logic sel;
    } ctrl_t;

    logic [15:0] div_r, h_count_r, v_count_r, row_base_r, addr_r;
    logic [7:0]  color_r;
    logic        hsync_r, vsync_r, vblank_r;
    ctrl_t       pipe_r [MEM_LATENCY];

    logic        tick_s, h_wrap_s, v_wrap_s, active_next_s;
    logic [15:0] div_next_s, h_next_s, v_next_s, row_base_next_s, addr_next_s;
    ctrl_t       ctrl_s, tap_s;

    // Next-state of the timing counters, row base and read address.
    // The address is built from the next counter values so it stays in step with the counters.
    always_comb begin
        tick_s   = (div_r == DIV_LAST);
        h_wrap_s = tick_s && (h_count_r == H_LAST);
        v_wrap_s = h_wrap_s && (v_count_r == V_LAST);

        if (tick_s) begin
            div_next_s = 16'd0;
        end else begin
            div_next_s = div_r + 16'd1;
        end

        if (h_wrap_s) begin
            h_next_s = 16'd0;
        end else if (tick_s) begin
            h_next_s = h_count_r + 16'd1;
        end else begin
            h_next_s = h_count_r;
        end

        if (v_wrap_s) begin
            v_next_s = 16'd0;
        end else if (h_wrap_s) begin
            v_next_s = v_count_r + 16'd1;
        end else begin
            v_next_s = v_count_r;
        end

        // Frame wrap wins over the per-row advance.
        if (v_wrap_s) begin
            row_base_next_s = 16'd0;
        end else if (h_wrap_s && (v_count_r < V_ACT) &&
                     (((v_count_r + 16'd1) & SCALE_MASK) == 16'd0)) begin
            row_base_next_s = row_base_r + ROW_WORDS;
        end else begin
            row_base_next_s = row_base_r;
        end

        active_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
        if (active_next_s) begin
            addr_next_s = BASE_ADDR + row_base_next_s + (h_next_s >> (SCALE_LOG2 + 1));
        end else begin
            addr_next_s = BASE_ADDR + row_base_next_s;
        end
    end

    // Control bits decoded from the current counters, and the tap at the end of the delay line.
    always_comb begin
        ctrl_s.act = (h_count_r < H_ACT) && (v_count_r < V_ACT);
        ctrl_s.hs  = (h_count_r >= HS_START) && (h_count_r < HS_END);
        ctrl_s.vs  = (v_count_r >= VS_START) && (v_count_r < VS_END);
        ctrl_s.vb  = (v_count_r >= V_ACT);
        ctrl_s.sel = h_count_r[SCALE_LOG2];
        tap_s      = pipe_r[MEM_LATENCY-1];
    end

    // Timing counters, row base and registered read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= 16'd0;
            h_count_r  <= 16'd0;
            v_count_r  <= 16'd0;
            row_base_r <= 16'd0;
            addr_r     <= BASE_ADDR;
        end else begin
            div_r      <= div_next_s;
            h_count_r  <= h_next_s;
            v_count_r  <= v_next_s;
            row_base_r <= row_base_next_s;
            addr_r     <= addr_next_s;
        end
    end

    // Control delay line matching the read latency, plus the registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= ctrl_t'(5'b0);
            end
            color_r  <= 8'h00;
            hsync_r  <= ~SYNC_POL;
            vsync_r  <= ~SYNC_POL;
            vblank_r <= 1'b0;
        end else begin
            pipe_r[0] <= ctrl_s;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            if (tap_s.act) begin
                color_r <= tap_s.sel ? vga.vgaData[7:0] : vga.vgaData[15:8];
            end else begin
                color_r <= 8'h00;
            end
            hsync_r  <= ~(tap_s.hs ^ SYNC_POL);
            vsync_r  <= ~(tap_s.vs ^ SYNC_POL);
            vblank_r <= tap_s.vb;
        end
    end

    assign vga.vgaAddress = addr_r;
    assign vga.colorOut   = color_r;
    assign vga.Hsync      = hsync_r;
    assign vga.Vsync      = vsync_r;
    assign vga.vblank     = vblank_r;
endmodule

// File: tb/tb_vga_scanout_engine.sv
// Scoreboard bench for vga_scanout_engine: two small-timing instances (unscaled/fast and
// scaled/divided/long-latency) checked cycle by cycle against an arithmetic reference model.
module tb_vga_scanout_engine;
    localparam int LA = 1;
    localparam int LB = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_scanout_engine_if ifa ();
    vga_scanout_engine_if ifb ();

    vga_scanout_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(1), .MEM_LATENCY(LA), .SCALE_LOG2(0),
        .BASE_ADDR(16'h0000), .SYNC_POL(1'b0)
    ) dut_a (.clk(clk), .reset(reset), .vga(ifa));

    vga_scanout_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(2), .MEM_LATENCY(LB), .SCALE_LOG2(1),
        .BASE_ADDR(16'h0100), .SYNC_POL(1'b1)
    ) dut_b (.clk(clk), .reset(reset), .vga(ifb));

    // Synchronous-read memories returning {addr[7:0], ~addr[7:0]} after L cycles.
    logic [15:0] mem_a [LA];
    logic [15:0] mem_b [LB];
    always @(posedge clk) begin
        mem_a[0] <= {ifa.vgaAddress[7:0], ~ifa.vgaAddress[7:0]};
        for (int i = 1; i < LA; i++) mem_a[i] <= mem_a[i-1];
        mem_b[0] <= {ifb.vgaAddress[7:0], ~ifb.vgaAddress[7:0]};
        for (int i = 1; i < LB; i++) mem_b[i] <= mem_b[i-1];
    end
    assign ifa.vgaData = mem_a[LA-1];
    assign ifb.vgaData = mem_b[LB-1];

    typedef struct packed {
        logic [15:0] addr;
        logic        act;
        logic [7:0]  color;
        logic        hs;
        logic        vs;
        logic        vb;
    } exp_t;

    typedef struct packed {
        logic [7:0] color;
        logic       hs;
        logic       vs;
        logic       vb;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    int   k;
    int   vs_a, vs_b;
    out_t qa[$];
    out_t qb[$];

    // Reference for cycle k after reset: H_TOTAL=14, V_TOTAL=7, pixel index = k / pd.
    function automatic exp_t model(int kk, int pd, int s, logic [15:0] base, logic pol);
        exp_t        e;
        int          p, h, v, fx, w;
        logic [15:0] a;
        p  = kk / pd;
        h  = p % 14;
        v  = (p / 14) % 7;
        w  = (8 >> s) / 2;
        fx = h >> s;
        a  = base + 16'((v >> s) * w + (fx >> 1));
        e.addr  = a;
        e.act   = (h < 8) && (v < 4);
        e.color = e.act ? (((fx % 2) == 1) ? ~a[7:0] : a[7:0]) : 8'h00;
        e.hs    = (h >= 10 && h < 12) ? pol : ~pol;
        e.vs    = (v == 5) ? pol : ~pol;
        e.vb    = (v >= 4);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_addr_a",  32'(ifa.vgaAddress), 32'h0000);
        chk("rst_pins_a",  32'({ifa.colorOut, ifa.Hsync, ifa.Vsync, ifa.vblank}), 32'h006);
        chk("rst_addr_b",  32'(ifb.vgaAddress), 32'h0100);
        chk("rst_pins_b",  32'({ifb.colorOut, ifb.Hsync, ifb.Vsync, ifb.vblank}), 32'h000);
    endtask

    // Pipeline starts full of reset-valued outputs for L+1 cycles.
    task automatic sb_reset();
        qa.delete();
        qb.delete();
        for (int i = 0; i <= LA; i++) qa.push_back(out_t'({8'h00, 1'b1, 1'b1, 1'b0}));
        for (int i = 0; i <= LB; i++) qb.push_back(out_t'({8'h00, 1'b0, 1'b0, 1'b0}));
        k = 0;
    endtask

    task automatic step();
        exp_t ea, eb;
        out_t oa, ob;
        ea = model(k, 1, 0, 16'h0000, 1'b0);
        eb = model(k, 2, 1, 16'h0100, 1'b1);
        qa.push_back(out_t'({ea.color, ea.hs, ea.vs, ea.vb}));
        qb.push_back(out_t'({eb.color, eb.hs, eb.vs, eb.vb}));
        if (ea.act) chk("addr_a", 32'(ifa.vgaAddress), 32'(ea.addr));
        if (eb.act) chk("addr_b", 32'(ifb.vgaAddress), 32'(eb.addr));
        oa = qa.pop_front();
        ob = qb.pop_front();
        chk("pins_a", 32'({ifa.colorOut, ifa.Hsync, ifa.Vsync, ifa.vblank}), 32'(oa));
        chk("pins_b", 32'({ifb.colorOut, ifb.Hsync, ifb.Vsync, ifb.vblank}), 32'(ob));
        if (ifa.Vsync === 1'b0) vs_a++;
        if (ifb.Vsync === 1'b1) vs_b++;
        k++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();
        reset = 1'b0;
        sb_reset();
        vs_a = 0;
        vs_b = 0;

        // Into line 2 of instance A, then a one-cycle reset.
        repeat (31) step();
        reset = 1'b1;
        @(negedge clk);
        check_reset();
        reset = 1'b0;
        sb_reset();

        // Four frames of A, two frames of B.
        vs_a = 0;
        vs_b = 0;
        repeat (392) step();
        chk("vsync_cycles_a", 32'(vs_a), 32'd56);
        chk("vsync_cycles_b", 32'(vs_b), 32'd56);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
